// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code constants and controller state encoding
package ps2_pkg;
   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;
   typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;
endpackage

// File: rtl/ps2_scan_ctrl_if.sv
// ps2_scan_ctrl_if: keyboard FIFO handshake, decoded key events and status
interface ps2_scan_ctrl_if #(parameter int CNT_W = 8);
   logic [7:0]       kb_data;
   logic             kb_ready;
   logic             kb_overflow;
   logic             nextdata_n;
   logic             evt_valid;
   logic [7:0]       evt_code;
   logic             evt_ext;
   logic             evt_make;
   logic             evt_repeat;
   logic [7:0]       held_code;
   logic             held_ext;
   logic             key_down;
   logic [CNT_W-1:0] press_cnt;
   logic             ovf_sticky;
   logic             ovf_clr;
   modport master (
      input  kb_data, kb_ready, kb_overflow, ovf_clr,
      output nextdata_n, evt_valid, evt_code, evt_ext, evt_make, evt_repeat,
             held_code, held_ext, key_down, press_cnt, ovf_sticky
   );
   modport slave (
      output kb_data, kb_ready, kb_overflow, ovf_clr,
      input  nextdata_n, evt_valid, evt_code, evt_ext, evt_make, evt_repeat,
             held_code, held_ext, key_down, press_cnt, ovf_sticky
   );
endinterface

// File: rtl/ps2_evt_decode.sv
// ps2_evt_decode: classifies a scan byte and computes next prefix/held-key state
module ps2_evt_decode
   import ps2_pkg::*;
(
   input  logic [7:0] data,
   input  logic       ext,
   input  logic       brk,
   input  logic [7:0] held_code,
   input  logic       held_ext,
   input  logic       key_down,
   output logic       evt,
   output logic       make,
   output logic       rpt,
   output logic       inc,
   output logic       ext_nxt,
   output logic       brk_nxt,
   output logic [7:0] held_code_nxt,
   output logic       held_ext_nxt,
   output logic       key_down_nxt
);
   logic pfx_e, pfx_b, match;
   // Prefix bytes only update flags; anything else is a release, repeat or press
   always_comb begin
      pfx_e         = data == SC_EXT;
      pfx_b         = data == SC_BRK;
      match         = data == held_code && ext == held_ext;
      evt           = !pfx_e && !pfx_b;
      make          = !brk;
      rpt           = evt && !brk && key_down && match;
      inc           = evt && !brk && !rpt;
      ext_nxt       = pfx_e ? 1'b1 : evt ? 1'b0 : ext;
      brk_nxt       = pfx_b ? 1'b1 : evt ? 1'b0 : brk;
      held_code_nxt = inc ? data : held_code;
      held_ext_nxt  = inc ? ext : held_ext;
      key_down_nxt  = inc ? 1'b1 : (evt && brk && match) ? 1'b0 : key_down;
   end
endmodule

// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: pops PS/2 scan bytes from a keyboard FIFO and decodes key events
module ps2_scan_ctrl #(
   parameter int CNT_W  = 8,
   parameter int SETTLE = 1
) (
   input logic            clk,
   input logic            resetn,
   ps2_scan_ctrl_if.master bus
);
   import ps2_pkg::*;
   localparam int SW = $clog2(SETTLE + 2);
   state_t           state, state_nxt;
   logic [SW-1:0]    cnt;
   logic [7:0]       data_q;
   logic             ext, brk;
   logic [7:0]       held_code;
   logic             held_ext, key_down;
   logic [CNT_W-1:0] press_cnt;
   logic             ovf_sticky;
   logic             evt_valid, evt_ext, evt_make, evt_repeat;
   logic [7:0]       evt_code;
   logic             pop, ovf_rise;
   logic             d_evt, d_make, d_rpt, d_inc, d_ext, d_brk, d_held_ext, d_key_down;
   logic [7:0]       d_held_code;
   ps2_evt_decode u_dec (
      .data(data_q),
      .ext(ext),
      .brk(brk),
      .held_code(held_code),
      .held_ext(held_ext),
      .key_down(key_down),
      .evt(d_evt),
      .make(d_make),
      .rpt(d_rpt),
      .inc(d_inc),
      .ext_nxt(d_ext),
      .brk_nxt(d_brk),
      .held_code_nxt(d_held_code),
      .held_ext_nxt(d_held_ext),
      .key_down_nxt(d_key_down)
   );
   // Next state: one pop per byte, then a fixed settle window before sampling ready again
   always_comb begin
      pop       = state == POP;
      ovf_rise  = bus.kb_overflow && !ovf_sticky;
      state_nxt = state == IDLE ? (bus.kb_ready ? POP : IDLE)
                : state == POP  ? (SETTLE == 0 ? IDLE : ps2_pkg::SETTLE)
                : (cnt == SW'(SETTLE - 1) ? IDLE : ps2_pkg::SETTLE);
   end
   // State register and inline settle counter
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= state == ps2_pkg::SETTLE ? cnt + 1'b1 : '0;
      end
   end
   // Latch the FIFO head byte when leaving IDLE
   always_ff @(posedge clk) begin
      if (!resetn) data_q <= '0;
      else if (state == IDLE && bus.kb_ready) data_q <= bus.kb_data;
   end
   // Commit decode results, event outputs, press counter and overflow flag
   always_ff @(posedge clk) begin
      if (!resetn) begin
         evt_valid  <= 1'b0;
         evt_code   <= '0;
         evt_ext    <= 1'b0;
         evt_make   <= 1'b0;
         evt_repeat <= 1'b0;
         held_code  <= '0;
         held_ext   <= 1'b0;
         key_down   <= 1'b0;
         press_cnt  <= '0;
         ext        <= 1'b0;
         brk        <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         evt_valid <= pop && d_evt;
         if (pop && d_evt) begin
            evt_code   <= data_q;
            evt_ext    <= ext;
            evt_make   <= d_make;
            evt_repeat <= d_rpt;
         end
         if (pop) begin
            held_code <= d_held_code;
            held_ext  <= d_held_ext;
            key_down  <= d_key_down;
         end
         if (pop && d_inc) press_cnt <= press_cnt + 1'b1;
         ext        <= ovf_rise ? 1'b0 : pop ? d_ext : ext;
         brk        <= ovf_rise ? 1'b0 : pop ? d_brk : brk;
         ovf_sticky <= bus.kb_overflow || (ovf_sticky && !bus.ovf_clr);
      end
   end
   assign bus.nextdata_n = !pop;
   assign bus.evt_valid  = evt_valid;
   assign bus.evt_code   = evt_code;
   assign bus.evt_ext    = evt_ext;
   assign bus.evt_make   = evt_make;
   assign bus.evt_repeat = evt_repeat;
   assign bus.held_code  = held_code;
   assign bus.held_ext   = held_ext;
   assign bus.key_down   = key_down;
   assign bus.press_cnt  = press_cnt;
   assign bus.ovf_sticky = ovf_sticky;
endmodule
